dbus_arbiter: RTL and testbench

Round-robin arbiter that shares one data-bus port (data memory plus the address-bit-31 MMIO region: console character writes and the simulation-finish word) among the `NCORES` CPU cores of the multicore `main`. At most one transaction is outstanding downstream at a time. A transaction is captured from the granted core, issued downstream with a valid/ready handshake, and, for reads, the response is routed back to that core. The block sits between each core's `dbus_*` port and the shared memory/MMIO port.

---
 rtl/dbus_arbiter.sv | 145 ++++++++++++++
 tb/tb_dbus_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one downstream data-bus port among NCORES cores.
// One transaction is outstanding at a time; read data is routed back to the granted core.
module dbus_arbiter #(
   parameter int NCORES = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NCORES-1:0]              req_valid_i,
   input  logic [NCORES-1:0]              req_we_i,
   input  logic [NCORES*ADDR_W-1:0]       req_addr_i,
   input  logic [NCORES*DATA_W-1:0]       req_wdata_i,
   input  logic [NCORES*(DATA_W/8)-1:0]   req_wstrb_i,
   output logic [NCORES-1:0]              req_ready_o,
   output logic [NCORES-1:0]              rsp_valid_o,
   output logic [DATA_W-1:0]              rsp_rdata_o,
   output logic                           mem_req_valid_o,
   input  logic                           mem_req_ready_i,
   output logic                           mem_we_o,
   output logic [ADDR_W-1:0]              mem_addr_o,
   output logic [DATA_W-1:0]              mem_wdata_o,
   output logic [DATA_W/8-1:0]            mem_wstrb_o,
   input  logic                           mem_rsp_valid_i,
   input  logic [DATA_W-1:0]              mem_rsp_rdata_i,
   output logic [$clog2(NCORES)-1:0]      grant_o
);

   // state      | meaning
   // S_IDLE     | no transaction held; arbitrate among requesting cores
   // S_ISSUE    | captured request presented downstream, waiting for ready
   // S_WAIT_RSP | read accepted downstream, waiting for response data

   localparam int IW = $clog2(NCORES);
   localparam int SW = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_RSP
   } state_e;

   state_e            state_q, state_d;
   logic [IW-1:0]     rr_q, rr_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [SW-1:0]     wstrb_q, wstrb_d;

   logic              arb_found;
   logic [IW-1:0]     arb_sel;
   logic [IW-1:0]     arb_idx;
   logic [NCORES-1:0] grant_oh;

   // First requester at or after rr, scanning modulo NCORES.
   always_comb begin
      arb_found = 1'b0;
      arb_sel   = '0;
      arb_idx   = '0;
      for (int i = 0; i < NCORES; i++) begin
         arb_idx = IW'((int'(rr_q) + i) % NCORES);
         if (!arb_found && req_valid_i[arb_idx]) begin
            arb_found = 1'b1;
            arb_sel   = arb_idx;
         end
      end
   end

   always_comb begin
      grant_oh          = '0;
      grant_oh[grant_q] = 1'b1;
   end

   always_comb begin
      state_d         = state_q;
      rr_d            = rr_q;
      grant_d         = grant_q;
      we_d            = we_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      wstrb_d         = wstrb_q;
      req_ready_o     = '0;
      rsp_valid_o     = '0;
      rsp_rdata_o     = '0;
      mem_req_valid_o = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               grant_d = arb_sel;
               rr_d    = (arb_sel == IW'(NCORES - 1)) ? '0 : arb_sel + 1'b1;
               we_d    = req_we_i[arb_sel];
               addr_d  = req_addr_i[arb_sel*ADDR_W +: ADDR_W];
               wdata_d = req_wdata_i[arb_sel*DATA_W +: DATA_W];
               wstrb_d = req_wstrb_i[arb_sel*SW +: SW];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem_req_valid_o = 1'b1;
            if (mem_req_ready_i) begin
               req_ready_o = grant_oh;
               state_d     = we_q ? S_IDLE : S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            if (mem_rsp_valid_i) begin
               rsp_valid_o = grant_oh;
               rsp_rdata_o = mem_rsp_rdata_i;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
      end
   end

   // Captured fields drive the downstream port directly so they hold steady under backpressure.
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_wstrb_o = wstrb_q;
   assign grant_o     = grant_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: per-cycle vector table plus contention and reset sequences.
module tb_dbus_arbiter;

   localparam int NC = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [NC-1:0]     req_valid_i;
   logic [NC-1:0]     req_we_i;
   logic [NC*AW-1:0]  req_addr_i;
   logic [NC*DW-1:0]  req_wdata_i;
   logic [NC*4-1:0]   req_wstrb_i;
   logic [NC-1:0]     req_ready_o;
   logic [NC-1:0]     rsp_valid_o;
   logic [DW-1:0]     rsp_rdata_o;
   logic              mem_req_valid_o;
   logic              mem_req_ready_i;
   logic              mem_we_o;
   logic [AW-1:0]     mem_addr_o;
   logic [DW-1:0]     mem_wdata_o;
   logic [3:0]        mem_wstrb_o;
   logic              mem_rsp_valid_i;
   logic [DW-1:0]     mem_rsp_rdata_i;
   logic [1:0]        grant_o;

   dbus_arbiter #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
      .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_wstrb_o(mem_wstrb_o), .mem_rsp_valid_i(mem_rsp_valid_i),
      .mem_rsp_rdata_i(mem_rsp_rdata_i), .grant_o(grant_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_fail = 0;

   logic [AW-1:0] addr_c  [NC];
   logic [DW-1:0] wdata_c [NC];

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  we;
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        emv;
      logic [1:0]  eg;
      logic [3:0]  erdy;
      logic [3:0]  ersp;
      logic [31:0] erd;
      logic        ewe;
   } vec_t;

   vec_t tv [22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int   ready_cnt [NC];
      int   n_txn;
      logic [1:0] prev_g;

      addr_c[0] = 32'h0000_1000; wdata_c[0] = 32'h1111_1111;
      addr_c[1] = 32'h0000_2000; wdata_c[1] = 32'h2222_2222;
      addr_c[2] = 32'h8000_0000; wdata_c[2] = 32'h0000_0041;
      addr_c[3] = 32'h0000_3000; wdata_c[3] = 32'h3333_3333;
      for (int k = 0; k < NC; k++) begin
         req_addr_i[k*AW +: AW]  = addr_c[k];
         req_wdata_i[k*DW +: DW] = wdata_c[k];
      end
      req_wstrb_i = '1;

      //           req      we       rdy  rv   rd            emv  eg     erdy     ersp     erd           ewe
      tv[0]  = '{4'b0100, 4'b0100, 1'b1, 1'b0, 32'h0,        1'b0, 2'd0, 4'b0000, 4'b0000, 32'h0,        1'b0};
      tv[1]  = '{4'b0100, 4'b0100, 1'b1, 1'b0, 32'h0,        1'b1, 2'd2, 4'b0100, 4'b0000, 32'h0,        1'b1};
      tv[2]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0,        1'b0, 2'd2, 4'b0000, 4'b0000, 32'h0,        1'b0};
      tv[3]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0,        1'b1, 2'd0, 4'b0001, 4'b0000, 32'h0,        1'b0};
      tv[4]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0,        1'b0, 2'd0, 4'b0000, 4'b0000, 32'h0,        1'b0};
      tv[5]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0,        1'b0, 2'd0, 4'b0000, 4'b0000, 32'h0,        1'b0};
      tv[6]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 2'd0, 4'b0000, 4'b0001, 32'hDEADBEEF, 1'b0};
      tv[7]  = '{4'b1000, 4'b1000, 1'b1, 1'b0, 32'h0,        1'b0, 2'd0, 4'b0000, 4'b0000, 32'h0,        1'b0};
      tv[8]  = '{4'b1000, 4'b1000, 1'b1, 1'b0, 32'h0,        1'b1, 2'd3, 4'b1000, 4'b0000, 32'h0,        1'b1};
      tv[9]  = '{4'b1000, 4'b1000, 1'b1, 1'b0, 32'h0,        1'b0, 2'd3, 4'b0000, 4'b0000, 32'h0,        1'b0};
      tv[10] = '{4'b1000, 4'b1000, 1'b1, 1'b0, 32'h0,        1'b1, 2'd3, 4'b1000, 4'b0000, 32'h0,        1'b1};
      tv[11] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 32'h12345678, 1'b0, 2'd3, 4'b0000, 4'b0000, 32'h0,        1'b0};
      tv[12] = '{4'b0110, 4'b0110, 1'b0, 1'b0, 32'h0,        1'b0, 2'd3, 4'b0000, 4'b0000, 32'h0,        1'b0};
      tv[13] = '{4'b0110, 4'b0110, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 2'd1, 4'b0000, 4'b0000, 32'h0,        1'b1};
      tv[14] = '{4'b0110, 4'b0110, 1'b0, 1'b0, 32'h0,        1'b1, 2'd1, 4'b0000, 4'b0000, 32'h0,        1'b1};
      tv[15] = '{4'b0110, 4'b0110, 1'b0, 1'b0, 32'h0,        1'b1, 2'd1, 4'b0000, 4'b0000, 32'h0,        1'b1};
      tv[16] = '{4'b0110, 4'b0110, 1'b0, 1'b0, 32'h0,        1'b1, 2'd1, 4'b0000, 4'b0000, 32'h0,        1'b1};
      tv[17] = '{4'b0110, 4'b0110, 1'b0, 1'b0, 32'h0,        1'b1, 2'd1, 4'b0000, 4'b0000, 32'h0,        1'b1};
      tv[18] = '{4'b0110, 4'b0110, 1'b1, 1'b0, 32'h0,        1'b1, 2'd1, 4'b0010, 4'b0000, 32'h0,        1'b1};
      tv[19] = '{4'b0100, 4'b0100, 1'b1, 1'b0, 32'h0,        1'b0, 2'd1, 4'b0000, 4'b0000, 32'h0,        1'b0};
      tv[20] = '{4'b0100, 4'b0100, 1'b1, 1'b0, 32'h0,        1'b1, 2'd2, 4'b0100, 4'b0000, 32'h0,        1'b1};
      tv[21] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0,        1'b0, 2'd2, 4'b0000, 4'b0000, 32'h0,        1'b0};

      // Reset values, with requests present to show reset dominates.
      rst_ni = 1'b0;
      req_valid_i = 4'b1111; req_we_i = 4'b1111;
      mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'hFFFF_FFFF;
      @(negedge clk_i);
      chk("rst_mem_valid", 32'(mem_req_valid_o), 32'h0);
      chk("rst_ready",     32'(req_ready_o), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
      chk("rst_grant",     32'(grant_o), 32'h0);
      chk("rst_fields",    {31'(mem_addr_o | mem_wdata_o | 32'(mem_wstrb_o)), mem_we_o}, 32'h0);
      req_valid_i = '0; req_we_i = '0; mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = '0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      for (int i = 0; i < 22; i++) begin
         req_valid_i     = tv[i].req;
         req_we_i        = tv[i].we;
         mem_req_ready_i = tv[i].rdy;
         mem_rsp_valid_i = tv[i].rv;
         mem_rsp_rdata_i = tv[i].rd;
         @(negedge clk_i);
         chk($sformatf("v%0d mem_valid", i), 32'(mem_req_valid_o), 32'(tv[i].emv));
         chk($sformatf("v%0d grant", i),     32'(grant_o), 32'(tv[i].eg));
         chk($sformatf("v%0d req_ready", i), 32'(req_ready_o), 32'(tv[i].erdy));
         chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid_o), 32'(tv[i].ersp));
         chk($sformatf("v%0d rsp_rdata", i), rsp_rdata_o, tv[i].erd);
         if (tv[i].emv) begin
            chk($sformatf("v%0d mem_addr", i),  mem_addr_o, addr_c[tv[i].eg]);
            chk($sformatf("v%0d mem_we", i),    32'(mem_we_o), 32'(tv[i].ewe));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata_o, wdata_c[tv[i].eg]);
            chk($sformatf("v%0d mem_wstrb", i), 32'(mem_wstrb_o), 32'hF);
         end
         next_cycle();
      end

      // Contention: all cores continuously request writes from reset.
      req_valid_i = '0; req_we_i = '0; mem_rsp_valid_i = 1'b0; mem_req_ready_i = 1'b1;
      do_reset();
      req_valid_i = 4'b1111; req_we_i = 4'b1111;
      n_txn = 0;
      for (int k = 0; k < NC; k++) ready_cnt[k] = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk_i);
         if (req_ready_o != '0) begin
            chk($sformatf("cont t%0d grant", n_txn), 32'(grant_o), 32'(n_txn % NC));
            chk($sformatf("cont t%0d ready", n_txn), 32'(req_ready_o), 32'(4'b0001 << (n_txn % NC)));
            for (int k = 0; k < NC; k++) if (req_ready_o[k]) ready_cnt[k]++;
            n_txn++;
         end
         next_cycle();
      end
      chk("cont txn_count", 32'(n_txn), 32'd8);
      for (int k = 0; k < NC; k++) chk($sformatf("cont core%0d readies", k), 32'(ready_cnt[k]), 32'd2);

      // Reset mid-read, late response dropped, next grant from rr=0.
      req_valid_i = '0; req_we_i = '0;
      do_reset();
      req_valid_i = 4'b0010; req_we_i = 4'b0000; mem_req_ready_i = 1'b1;
      next_cycle();
      @(negedge clk_i);
      chk("mid ready", 32'(req_ready_o), 32'h2);
      next_cycle();
      req_valid_i = '0;
      @(negedge clk_i);
      chk("mid wait_no_valid", 32'(mem_req_valid_o), 32'h0);
      prev_g = grant_o;
      chk("mid grant_pre", 32'(prev_g), 32'h1);
      next_cycle();
      rst_ni = 1'b0;
      #3;
      chk("mid rst_grant", 32'(grant_o), 32'h0);
      chk("mid rst_addr",  mem_addr_o, 32'h0);
      chk("mid rst_mem_valid", 32'(mem_req_valid_o), 32'h0);
      next_cycle();
      rst_ni = 1'b1;
      mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'hBAD0_BAD0;
      @(negedge clk_i);
      chk("mid late_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("mid late_rsp_rdata", rsp_rdata_o, 32'h0);
      next_cycle();
      mem_rsp_valid_i = 1'b0;
      req_valid_i = 4'b1010; req_we_i = 4'b1010;
      @(negedge clk_i);
      chk("mid idle_mem_valid", 32'(mem_req_valid_o), 32'h0);
      next_cycle();
      @(negedge clk_i);
      chk("mid regrant_valid", 32'(mem_req_valid_o), 32'h1);
      chk("mid regrant_grant", 32'(grant_o), 32'h1);
      chk("mid regrant_ready", 32'(req_ready_o), 32'h2);
      next_cycle();
      req_valid_i = '0;
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
